log2_seq: RTL and testbench
===========================

LOG2_SEQ -- requirements
Module: log2_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the input operand width in bits (legal: >=2).
REQ-002 Parameter FRAC, default 4, SHALL set the number of fractional result bits (legal: 0..WIDTH-1).
REQ-003 Derived constant IW = $clog2(WIDTH) SHALL be the integer result bits; RW = IW+FRAC SHALL be the result width.
REQ-004 clk  input  1  single clock; all state SHALL change on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 number  input  WIDTH  unsigned operand.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  RW  unsigned fixed-point log2(number); upper IW bits integer, lower FRAC bits fraction.
REQ-012 zero  output  1  set with result when number was 0.

Function
REQ-013 The FSM SHALL have states IDLE, NORM, ITER, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-015 in_valid&&in_ready at an edge SHALL capture number and move to NORM.
REQ-016 In NORM (one cycle): integer part = index of the highest set bit; mantissa m (WIDTH bits, value in [1,2) with WIDTH-1 fraction bits) = number shifted left so that bit WIDTH-1 is set.
REQ-017 From NORM: if FRAC=0 or number=0, go to DONE; otherwise go to ITER with iteration counter = 0.
REQ-018 Each ITER cycle: P = m*m (2*WIDTH bits); if P[2W-1]=1, fraction bit = 1 and m = P[2W-1:W]; else fraction bit = 0 and m = P[2W-2:W-1]; bits SHALL be produced MSB first.
REQ-019 Truncation SHALL be exactly as in REQ-018 (no rounding); the verification model SHALL use the same rule.
REQ-020 After FRAC ITER cycles, the FSM SHALL go to DONE.
REQ-021 Latency: operand accepted at edge T -> out_valid observed high after edge T+2+FRAC (T+2 for zero input or FRAC=0).
REQ-022 In DONE, out_valid SHALL be 1 and result/zero SHALL be stable until out_ready=1.
REQ-023 out_valid&&out_ready at an edge SHALL return to IDLE; no operand SHALL be accepted in that same cycle.
REQ-024 number=0 SHALL give result=0, zero=1; any nonzero number SHALL give zero=0.
REQ-025 number=1 SHALL give result=0; number=2^k SHALL give result=k<<FRAC with all fraction bits 0.
REQ-026 Outside DONE, result and zero SHALL hold their last value; out_valid SHALL be 0.
REQ-027 in_valid while busy SHALL be ignored; number SHALL be sampled only at the accept edge.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for a clock edge, force IDLE, out_valid=0, result=0, zero=0, and iteration counter=0.
REQ-029 A reset during NORM, ITER, or DONE SHALL discard the operation; no result SHALL be emitted for it.
REQ-030 After reset is released, the first posedge clk SHALL be able to accept an operand.

Structure
REQ-031 Package log2_pkg SHALL hold the FSM state type (IDLE/NORM/ITER/DONE) and the IW/RW width helper functions.
REQ-032 Leading-one detection SHALL be a combinational sub-module log2_lod (WIDTH in -> IW-bit index + found flag), instantiated once.
REQ-033 The squarer SHALL be one WIDTH x WIDTH multiplier, reused every ITER cycle.

Verification (WIDTH=8, FRAC=4 unless noted)
REQ-034 number=3 -> result=0x19 (1.1001b), zero=0, out_valid observed high after edge T+6.
REQ-035 number=255 -> 0x7F; number=128 -> 0x70; number=1 -> 0x00; all with zero=0.
REQ-036 number=0 -> result=0, zero=1, out_valid observed high after edge T+2.
REQ-037 Hold out_ready=0 for 10 cycles in DONE -> out_valid, result, and zero are stable and in_ready=0; in_valid pulses are ignored.
REQ-038 Assert reset=0 mid-ITER (between edges) -> out_valid and result go to 0 at once; after release, number=4 -> 0x20.
REQ-039 Sweep number 0..255 with random out_ready stalls, FRAC=0 and FRAC=4 -> every result matches the REQ-016/REQ-018 model.

Source files
------------

// File: rtl/log2_pkg.sv
// Shared types and width helpers for the sequential fixed-point log2 unit.
package log2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ITER,
        DONE
    } state_t;

    function automatic int calc_iw(input int width);
        return $clog2(width);
    endfunction

    function automatic int calc_rw(input int width, input int frac);
        return $clog2(width) + frac;
    endfunction

endpackage

// File: rtl/log2_lod.sv
// Combinational leading-one detector: index of the highest set bit plus a found flag.
module log2_lod
    import log2_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IW = calc_iw(WIDTH)
) (
    input  logic [WIDTH-1:0] number,
    output logic [IW-1:0]    index,
    output logic             found
);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (number[i]) begin
                index = IW'(i);
            end
        end
    end

    assign found = |number;

endmodule

// File: rtl/log2_seq.sv
// Sequential unsigned log2: integer part from a leading-one detector, fraction bits
// produced MSB first by repeated squaring of the normalised mantissa.
module log2_seq
    import log2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4,
    localparam int IW = calc_iw(WIDTH),
    localparam int RW = calc_rw(WIDTH, FRAC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] number,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    result,
    output logic             zero
);

    localparam int FW   = FRAC + 1;
    localparam int CW   = $clog2(FRAC + 2);
    localparam int LAST = (FRAC > 0) ? FRAC - 1 : 0;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   number_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [IW-1:0]      int_reg;
    logic [FW-1:0]      frac_reg;
    logic [CW-1:0]      cnt_reg;
    logic               zero_flag_reg;
    logic               out_valid_reg;
    logic [RW-1:0]      result_reg;
    logic               zero_reg;

    logic [IW-1:0]      lod_index;
    logic               lod_found;
    logic [IW-1:0]      shift;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_top;
    logic [RW-1:0]      assembled;

    log2_lod #(.WIDTH(WIDTH)) u_lod (
        .number (number_reg),
        .index  (lod_index),
        .found  (lod_found)
    );

    assign shift     = IW'(WIDTH - 1) - lod_index;
    assign prod      = {{WIDTH{1'b0}}, m_reg} * {{WIDTH{1'b0}}, m_reg};
    // prod_top[WIDTH] is the overflow bit; the two candidate mantissas are its neighbours.
    assign prod_top  = (WIDTH + 1)'(prod >> (WIDTH - 1));
    assign assembled = (RW'(int_reg) << FRAC) | RW'(frac_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                if (FRAC == 0 || !lod_found) begin
                    state_next = DONE;
                end else begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (cnt_reg == CW'(LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid_reg && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            number_reg    <= '0;
            m_reg         <= '0;
            int_reg       <= '0;
            frac_reg      <= '0;
            cnt_reg       <= '0;
            zero_flag_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        number_reg <= number;
                    end
                end
                NORM: begin
                    int_reg       <= lod_index;
                    m_reg         <= number_reg << shift;
                    zero_flag_reg <= !lod_found;
                    frac_reg      <= '0;
                    cnt_reg       <= '0;
                end
                ITER: begin
                    frac_reg <= (frac_reg << 1) | FW'(prod_top[WIDTH]);
                    m_reg    <= prod_top[WIDTH] ? prod_top[WIDTH:1] : prod_top[WIDTH-1:0];
                    cnt_reg  <= cnt_reg + 1'b1;
                end
                DONE: begin
                    // First DONE cycle publishes the result; it then holds until taken.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        result_reg    <= assembled;
                        zero_reg      <= zero_flag_reg;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_log2_seq.sv
// Randomised bench for log2_seq: FRAC=0 and FRAC=4 instances checked against an arithmetic model.
module tb_log2_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid [2];
    logic       in_ready [2];
    logic       out_valid[2];
    logic       out_ready[2];
    logic       zero     [2];
    logic [7:0] number   [2];
    logic [2:0] res0;
    logic [6:0] res4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    log2_seq #(.WIDTH(8), .FRAC(0)) u_frac0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .number    (number[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .result    (res0),
        .zero      (zero[0])
    );

    log2_seq #(.WIDTH(8), .FRAC(4)) u_frac4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .number    (number[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .result    (res4),
        .zero      (zero[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int frac_of(input int d);
        return (d == 1) ? 4 : 0;
    endfunction

    function automatic logic [31:0] res_of(input int d);
        return (d == 1) ? 32'(res4) : 32'(res0);
    endfunction

    // floor(log2 n) as integer part, then fraction bits by squaring a value in [1,2).
    function automatic int model(input int n, input int frac);
        int ip, m, p, r;
        if (n == 0) return 0;
        ip = $clog2(n + 1) - 1;
        m  = (n << (7 - ip)) & 255;
        r  = ip;
        for (int i = 0; i < frac; i++) begin
            p = m * m;
            if (p >= 32768) begin
                r = r * 2 + 1;
                m = p / 256;
            end else begin
                r = r * 2;
                m = (p / 128) & 255;
            end
        end
        return r;
    endfunction

    // Called at posedge+1 with the target instance idle.
    task automatic run(input int d, input int n, input int stall, input bit kick, input int exp);
        int lat;
        int exp_lat;
        lat     = 0;
        exp_lat = (n == 0 || frac_of(d) == 0) ? 2 : 2 + frac_of(d);
        check("in_ready_idle", 32'(in_ready[d]), 32'd1);
        number[d]   = 8'(n);
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        number[d]   = 8'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid[d]) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", res_of(d), 32'(exp));
        check("zero", 32'(zero[d]), 32'(n == 0));
        out_ready[d] = 1'b0;
        for (int i = 0; i < stall; i++) begin
            if (kick) begin
                in_valid[d] = 1'($urandom_range(0, 1));
                number[d]   = 8'($urandom);
            end
            @(posedge clk);
            #1;
            check("stall_valid", 32'(out_valid[d]), 32'd1);
            check("stall_result", res_of(d), 32'(exp));
            check("stall_zero", 32'(zero[d]), 32'(n == 0));
            check("stall_in_ready", 32'(in_ready[d]), 32'd0);
        end
        out_ready[d] = 1'b1;
        in_valid[d]  = 1'b1;
        number[d]    = 8'($urandom);
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        check("release_valid", 32'(out_valid[d]), 32'd0);
        check("no_accept_on_release", 32'(in_ready[d]), 32'd1);
        $display("txn frac=%0d number=%0d result=0x%0h zero=%0b latency=%0d stall=%0d",
                 frac_of(d), n, exp, n == 0, lat, stall);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            number[d]    = 8'd0;
        end
        #2;
        check("reset_valid", 32'(out_valid[1]), 32'd0);
        check("reset_result", res_of(1), 32'd0);
        check("reset_zero", 32'(zero[1]), 32'd0);
        check("reset_in_ready", 32'(in_ready[1]), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Known answers for the default configuration.
        run(1, 3,   0, 0, 'h19);
        run(1, 255, 1, 0, 'h7F);
        run(1, 128, 0, 0, 'h70);
        run(1, 1,   2, 0, 'h00);
        run(1, 0,   0, 0, 'h00);
        run(0, 5,   1, 0, 2);
        run(0, 0,   0, 0, 0);
        run(1, 200, 10, 1, model(200, 4));

        // Reset mid-ITER must clear outputs at once and discard the operation.
        run(1, 77, 0, 0, model(77, 4));
        number[1]   = 8'd200;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_valid", 32'(out_valid[1]), 32'd0);
        check("async_result", res_of(1), 32'd0);
        check("async_zero", 32'(zero[1]), 32'd0);
        check("async_in_ready", 32'(in_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run(1, 4, 2, 0, 'h20);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_valid", 32'(out_valid[1]), 32'd0);
        end

        for (int n = 0; n < 256; n++) begin
            run(1, n, int'($urandom_range(0, 3)), 1, model(n, 4));
            run(0, n, int'($urandom_range(0, 3)), 1, model(n, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
